// File: rtl/regfile.sv
// 32 x 32-bit MIPS register file: one write port, two write-first read ports.
// $0 is hardwired to zero; synchronous active-high reset beats any same-cycle write.

module decoder5to32 (
  input  logic [4:0]  in_i,
  input  logic        en_i,
  output logic [31:0] out_o
);
  always_comb begin
    out_o = '0;
    if (en_i) out_o[in_i] = 1'b1;
  end
endmodule

module regfile (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ctrl_writeEnable,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  input  logic [31:0] data_writeReg,
  output logic [31:0] data_readRegA,
  output logic [31:0] data_readRegB
);
  logic [31:0] load;
  logic [31:0] regs_q [1:31];
  logic [31:0] stored_a, stored_b;
  logic        wr_live, byp_a, byp_b;

  decoder5to32 u_wdec (
    .in_i  (ctrl_writeReg),
    .en_i  (ctrl_writeEnable),
    .out_o (load)
  );

  // Decoder bit 0 is the write-to-$0 case, which is dropped; registers 1..31 only.
  always_ff @(posedge clock) begin
    for (int unsigned i = 1; i < 32; i++) begin
      if (ctrl_reset)   regs_q[i] <= '0;
      else if (load[i]) regs_q[i] <= data_writeReg;
    end
  end

  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      if (ctrl_readRegA == 5'(i)) stored_a = regs_q[i];
      if (ctrl_readRegB == 5'(i)) stored_b = regs_q[i];
    end
  end

  // enable && !load[0] means a write to a nonzero register is in flight.
  assign wr_live = ctrl_writeEnable & ~load[0] & ~ctrl_reset;
  assign byp_a   = wr_live & (ctrl_writeReg == ctrl_readRegA);
  assign byp_b   = wr_live & (ctrl_writeReg == ctrl_readRegB);

  assign data_readRegA = byp_a ? data_writeReg : stored_a;
  assign data_readRegB = byp_b ? data_writeReg : stored_b;
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed test-plan steps plus random traffic
// compared against an array model of the architectural register state.

module tb_regfile;
  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_writeReg;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] mdl [32];

  regfile dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
    ctrl_reset       = rst;
    ctrl_writeEnable = we;
    ctrl_writeReg    = wa;
    data_writeReg    = wd;
    ctrl_readRegA    = ra;
    ctrl_readRegB    = rb;
  endtask

  // Expected read: the in-flight write if it is a real write to that address, else model state.
  function automatic logic [31:0] expect_rd(input logic [4:0] ra);
    if (!ctrl_reset && ctrl_writeEnable && ctrl_writeReg != 5'd0 && ctrl_writeReg == ra)
      return data_writeReg;
    return mdl[ra];
  endfunction

  task automatic apply(input string tag, input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
    drive(rst, we, wa, wd, ra, rb);
    #2;
    chk({tag, "_mA"}, data_readRegA, expect_rd(ra));
    chk({tag, "_mB"}, data_readRegB, expect_rd(rb));
  endtask

  task automatic tick();
    @(posedge clock);
    if (ctrl_reset) begin
      for (int k = 0; k < 32; k++) mdl[k] = '0;
    end else if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
      mdl[ctrl_writeReg] = data_writeReg;
    end
    #1;
  endtask

  initial begin
    logic [4:0]  ra, rb, wa;
    logic [31:0] pat;
    for (int k = 0; k < 32; k++) mdl[k] = '0;

    drive(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    tick();
    apply("post_reset", 1'b0, 1'b0, 5'd0, '0, 5'd1, 5'd31);
    chk("post_reset_A", data_readRegA, 32'h0);
    chk("post_reset_B", data_readRegB, 32'h0);
    tick();

    // Reset clears every register.
    for (int i = 1; i < 32; i++) begin
      apply("fill", 1'b0, 1'b1, 5'(i), 32'hFFFF_FFFF, 5'(i), 5'd0);
      tick();
    end
    apply("rst_cyc", 1'b1, 1'b0, 5'd0, '0, 5'd3, 5'd4);
    chk("rst_cyc_A", data_readRegA, 32'hFFFF_FFFF);
    tick();
    for (int i = 0; i < 32; i++) begin
      apply("rst_rd", 1'b0, 1'b0, 5'd0, '0, 5'(i), 5'(31 - i));
      chk("rst_rd_A", data_readRegA, 32'h0);
      chk("rst_rd_B", data_readRegB, 32'h0);
      tick();
    end

    // Write/readback sweep.
    for (int i = 1; i < 32; i++) begin
      apply("sweep_wr", 1'b0, 1'b1, 5'(i), i * 32'h0101_0101, 5'd0, 5'd0);
      tick();
    end
    for (int i = 1; i < 32; i++) begin
      apply("sweep_rd", 1'b0, 1'b0, 5'd0, '0, 5'(i), 5'(31 - i));
      chk("sweep_A", data_readRegA, i * 32'h0101_0101);
      chk("sweep_B", data_readRegB, (31 - i) * 32'h0101_0101);
      tick();
    end

    // $0 protection.
    apply("zero_wr", 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    chk("zero_wr_A", data_readRegA, 32'h0);
    chk("zero_wr_B", data_readRegB, 32'h0);
    tick();
    apply("zero_nx", 1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    chk("zero_nx_A", data_readRegA, 32'h0);
    chk("zero_nx_B", data_readRegB, 32'h0);
    tick();

    // Bypass on port A only, B unchanged.
    apply("byp_pre", 1'b0, 1'b1, 5'd5, 32'h1111_1111, 5'd0, 5'd0);
    tick();
    apply("byp", 1'b0, 1'b1, 5'd5, 32'h2222_2222, 5'd5, 5'd6);
    chk("byp_A", data_readRegA, 32'h2222_2222);
    chk("byp_B", data_readRegB, 32'h0606_0606);
    tick();
    apply("byp_nx", 1'b0, 1'b0, 5'd5, 32'h0, 5'd5, 5'd5);
    chk("byp_nx_A", data_readRegA, 32'h2222_2222);
    chk("byp_nx_B", data_readRegB, 32'h2222_2222);
    tick();

    // Reset colliding with a write.
    apply("col_pre", 1'b0, 1'b1, 5'd7, 32'hAAAA_AAAA, 5'd0, 5'd0);
    tick();
    apply("col", 1'b1, 1'b1, 5'd7, 32'h5555_5555, 5'd7, 5'd7);
    chk("col_A", data_readRegA, 32'hAAAA_AAAA);
    tick();
    apply("col_nx", 1'b0, 1'b0, 5'd0, '0, 5'd7, 5'd5);
    chk("col_nx_A", data_readRegA, 32'h0);
    chk("col_nx_B", data_readRegB, 32'h0);
    tick();

    // Disabled write leaves $9 alone and is not forwarded.
    apply("dis_pre", 1'b0, 1'b1, 5'd9, 32'h0000_0009, 5'd0, 5'd0);
    tick();
    apply("dis", 1'b0, 1'b0, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd9);
    chk("dis_A", data_readRegA, 32'h0000_0009);
    tick();
    apply("dis_nx", 1'b0, 1'b0, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd9);
    chk("dis_nx_A", data_readRegA, 32'h0000_0009);
    tick();

    // Back-to-back writes to one register, both ports bypassing.
    apply("b2b_1", 1'b0, 1'b1, 5'd3, 32'h0BAD_0001, 5'd0, 5'd0);
    tick();
    apply("b2b_2", 1'b0, 1'b1, 5'd3, 32'h0BAD_0002, 5'd3, 5'd3);
    chk("b2b_2_A", data_readRegA, 32'h0BAD_0002);
    chk("b2b_2_B", data_readRegB, 32'h0BAD_0002);
    tick();
    apply("b2b_nx", 1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd0);
    chk("b2b_nx_A", data_readRegA, 32'h0BAD_0002);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      wa  = 5'($urandom_range(0, 31));
      pat = $urandom;
      ra  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      apply("rand", ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), wa, pat, ra, rb);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
